// File: rtl/neural_unit_sequencer_if.sv
// NeuralUnit pin bundle: weight-bank load, sum trigger and result return.
// The sequencer is the master; the unit side is the slave.
interface neural_unit_sequencer_if;
    logic [7:0]  weight;
    logic [1:0]  address;
    logic        write;
    logic        sumTrigger;
    logic        layer_Sel;
    logic [31:0] layerOut;
    logic        layerDone;

    modport master (
        output weight,
        output address,
        output write,
        output sumTrigger,
        output layer_Sel,
        input  layerOut,
        input  layerDone
    );

    modport slave (
        input  weight,
        input  address,
        input  write,
        input  sumTrigger,
        input  layer_Sel,
        output layerOut,
        output layerDone
    );
endinterface

// File: rtl/neural_unit_sequencer.sv
// Layer-pass sequencer for one 4-input NeuralUnit: loads weights per
// neuron, triggers the summer, waits for done and captures the result.
module neural_unit_sequencer #(
    parameter  int NEURONS    = 4,
    parameter  int SETTLE_CYC = 2,
    parameter  int TIMEOUT    = 255,
    localparam int IW         = $clog2(NEURONS),
    localparam int AW         = $clog2(NEURONS * 4)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [7:0]             cfg_data,
    input  logic                   start,
    input  logic [IW:0]            num_neurons,
    input  logic                   layer_sel_in,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [31:0]            result,
    output logic [IW-1:0]          result_idx,
    output logic                   result_valid,
    neural_unit_sequencer_if.master unit
);

    localparam int DEPTH = NEURONS * 4;
    localparam int CMAX  = (TIMEOUT > SETTLE_CYC) ? TIMEOUT : SETTLE_CYC;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW:0]   NMAX     = (IW + 1)'(NEURONS);

    typedef enum logic [2:0] {
        IDLE, LOAD, SETTLE, TRIG, WAIT, NEXT, FIN, ERR
    } state_t;

    state_t state_q, state_d;

    logic [7:0]    store [DEPTH];
    logic [IW-1:0] n_q;
    logic [IW:0]   count_q;
    logic [1:0]    ld_q;
    logic [CW-1:0] cnt_q;
    logic          sel_q;
    logic          arm_q;
    logic [IW:0]   n_inc;

    assign n_inc = {1'b0, n_q} + (IW + 1)'(1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (start)
                    state_d = (num_neurons == '0) ? FIN : LOAD;
            LOAD:
                if (ld_q == 2'd3) state_d = SETTLE;
            SETTLE:
                if (cnt_q == SET_LAST) state_d = TRIG;
            TRIG:
                state_d = WAIT;
            WAIT:
                if (arm_q && unit.layerDone) state_d = NEXT;
                else if (cnt_q == TMO_LAST)  state_d = ERR;
            NEXT:
                state_d = (n_inc < count_q) ? LOAD : FIN;
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy            = (state_q != IDLE);
        done            = (state_q == FIN);
        error           = (state_q == ERR);
        result_valid    = (state_q == NEXT);
        unit.write      = (state_q == LOAD);
        unit.address    = (state_q == LOAD) ? ld_q : 2'd0;
        unit.weight     = (state_q == LOAD) ? store[{n_q, ld_q}] : 8'd0;
        unit.sumTrigger = (state_q == TRIG);
        unit.layer_Sel  = busy ? sel_q : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
            n_q        <= '0;
            count_q    <= '0;
            ld_q       <= '0;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            arm_q      <= 1'b0;
            result     <= '0;
            result_idx <= '0;
        end else begin
            if (state_q == IDLE && cfg_we && 32'(cfg_addr) < DEPTH)
                store[cfg_addr] <= cfg_data;
            unique case (state_q)
                IDLE:
                    if (start) begin
                        count_q <= (num_neurons > NMAX) ? NMAX : num_neurons;
                        sel_q   <= layer_sel_in;
                        n_q     <= '0;
                        ld_q    <= '0;
                    end
                LOAD: begin
                    ld_q  <= ld_q + 2'd1;
                    cnt_q <= '0;
                end
                SETTLE:
                    cnt_q <= cnt_q + CW'(1);
                TRIG: begin
                    cnt_q <= '0;
                    arm_q <= 1'b0;
                end
                WAIT: begin
                    // a done level left over from the last neuron must drop first
                    if (!unit.layerDone) arm_q <= 1'b1;
                    cnt_q <= cnt_q + CW'(1);
                    if (arm_q && unit.layerDone) begin
                        result     <= unit.layerOut;
                        result_idx <= n_q;
                    end
                end
                NEXT: begin
                    n_q  <= n_q + IW'(1);
                    ld_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neural_unit_sequencer.sv
// Directed bench for neural_unit_sequencer with a simple NeuralUnit model
// whose result is the sum of the four loaded weights.
module tb_neural_unit_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        start;
    logic [2:0]  num_neurons;
    logic        layer_sel_in;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] result;
    logic [1:0]  result_idx;
    logic        result_valid;

    neural_unit_sequencer_if uif ();

    neural_unit_sequencer #(
        .NEURONS    (4),
        .SETTLE_CYC (2),
        .TIMEOUT    (255)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .start        (start),
        .num_neurons  (num_neurons),
        .layer_sel_in (layer_sel_in),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .result       (result),
        .result_idx   (result_idx),
        .result_valid (result_valid),
        .unit         (uif.master)
    );

    always #5 clk = ~clk;

    // unit model: done pulses 6 cycles after sumTrigger
    logic [7:0]  wb [4];
    logic [31:0] lo = '0;
    logic        md = 1'b0;
    logic        force_hi = 1'b0;
    logic [2:0]  cd = '0;

    assign uif.layerOut  = lo;
    assign uif.layerDone = md | force_hi;

    initial for (int i = 0; i < 4; i++) wb[i] = '0;

    always @(posedge clk) begin
        if (uif.write) wb[uif.address] <= uif.weight;
        if (uif.sumTrigger) begin
            lo <= 32'(wb[0]) + 32'(wb[1]) + 32'(wb[2]) + 32'(wb[3]);
            cd <= 3'd5;
            md <= 1'b0;
        end else begin
            if (cd != 3'd0) cd <= cd - 3'd1;
            md <= (cd == 3'd1);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int nw, nr, nd, ne, nt;
    int t_fwr, t_ftrig, t_trig, t_done, t_err, c_end;
    int g_drop = -1;
    int g_junk = -1;
    int g_rst  = -1;
    logic [7:0]  exp_w [16];
    logic [31:0] exp_r [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic chk_idle(input string p);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_done"}, 32'(done), 0);
        chk({p, "_error"}, 32'(error), 0);
        chk({p, "_write"}, 32'(uif.write), 0);
        chk({p, "_weight"}, 32'(uif.weight), 0);
        chk({p, "_address"}, 32'(uif.address), 0);
        chk({p, "_trig"}, 32'(uif.sumTrigger), 0);
        chk({p, "_sel"}, 32'(uif.layer_Sel), 0);
        chk({p, "_result"}, result, 0);
        chk({p, "_ridx"}, 32'(result_idx), 0);
        chk({p, "_rvalid"}, 32'(result_valid), 0);
    endtask

    task automatic run_pass(input logic [2:0] num, input logic sel);
        int c;
        nw = 0; nr = 0; nd = 0; ne = 0; nt = 0;
        t_fwr = -1; t_ftrig = -1; t_trig = -1;
        t_done = -1; t_err = -1;
        num_neurons  = num;
        layer_sel_in = sel;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        chk("busy_c1", 32'(busy), 1);
        while (c < 400) begin
            if (c == g_drop) force_hi = 1'b0;
            if (c == g_junk) begin
                cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 8'hFF;
                start = 1'b1; num_neurons = 3'd1;
            end
            if (c == g_junk + 1) begin
                cfg_we = 1'b0; start = 1'b0;
            end
            if (uif.write) begin
                if (t_fwr < 0) t_fwr = c;
                if (nw < 16) begin
                    chk("wr_addr", 32'(uif.address), nw % 4);
                    chk("wr_weight", 32'(uif.weight), 32'(exp_w[nw]));
                end
                nw++;
            end
            if (uif.sumTrigger) begin
                if (t_ftrig < 0) t_ftrig = c;
                t_trig = c;
                nt++;
            end
            if (result_valid) begin
                if (nr < 4) begin
                    chk("rv_idx", 32'(result_idx), nr);
                    chk("rv_result", result, exp_r[nr]);
                end
                chk("rv_lat", c, t_trig + 7);
                nr++;
            end
            if (busy) chk("layer_sel", 32'(uif.layer_Sel), 32'(sel));
            if (done) begin nd++; t_done = c; end
            if (error) begin ne++; t_err = c; end
            if (c == g_rst) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                c++;
                chk_idle("mid_rst");
                break;
            end
            if (!busy) break;
            tick();
            c++;
        end
        c_end = c;
        chk("pass_end", 32'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; num_neurons = '0; layer_sel_in = 1'b0;
        tick();
        tick();
        chk_idle("rst");
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            exp_w[i] = 8'(i + 1);
            cfg_we   = 1'b1;
            cfg_addr = 4'(i);
            cfg_data = 8'(i + 1);
            tick();
        end
        cfg_we = 1'b0;
        exp_r[0] = 32'd10; exp_r[1] = 32'd26;
        exp_r[2] = 32'd42; exp_r[3] = 32'd58;

        // full pass: 4 neurons, 14-cycle neuron period
        run_pass(3'd4, 1'b1);
        chk("a_writes", nw, 16);
        chk("a_results", nr, 4);
        chk("a_dones", nd, 1);
        chk("a_errors", ne, 0);
        chk("a_trigs", nt, 4);
        chk("a_first_wr", t_fwr, 1);
        chk("a_first_trig", t_ftrig, 7);
        chk("a_done_cyc", t_done, 57);
        chk("a_end", c_end, 58);

        run_pass(3'd0, 1'b1);
        chk("z_writes", nw, 0);
        chk("z_trigs", nt, 0);
        chk("z_dones", nd, 1);
        chk("z_done_cyc", t_done, 1);
        chk("z_end", c_end, 2);

        // count clamped to 4; stray cfg write and start mid-pass
        g_junk = 3;
        run_pass(3'd7, 1'b0);
        g_junk = -1;
        chk("c_writes", nw, 16);
        chk("c_results", nr, 4);
        chk("c_dones", nd, 1);
        chk("c_done_cyc", t_done, 57);

        run_pass(3'd1, 1'b1);
        chk("o_results", nr, 1);
        chk("o_done_cyc", t_done, 15);

        // stale done high until cycle 10, then the real pulse
        force_hi = 1'b1;
        g_drop = 10;
        run_pass(3'd1, 1'b1);
        g_drop = -1;
        chk("s_results", nr, 1);
        chk("s_errors", ne, 0);
        chk("s_done_cyc", t_done, 15);

        force_hi = 1'b1;
        run_pass(3'd2, 1'b1);
        force_hi = 1'b0;
        chk("t_errors", ne, 1);
        chk("t_results", nr, 0);
        chk("t_dones", nd, 0);
        chk("t_writes", nw, 4);
        chk("t_err_cyc", t_err, 7 + 256);
        chk("t_end", c_end, 7 + 257);

        // reset during WAIT of neuron 2
        g_rst = 38;
        run_pass(3'd4, 1'b1);
        g_rst = -1;
        chk("r_results", nr, 2);
        chk("r_dones", nd, 0);
        chk("r_errors", ne, 0);
        chk("r_end", c_end, 39);

        for (int i = 0; i < 16; i++) exp_w[i] = 8'd0;
        for (int i = 0; i < 4; i++) exp_r[i] = 32'd0;
        run_pass(3'd2, 1'b0);
        chk("e_writes", nw, 8);
        chk("e_results", nr, 2);
        chk("e_done_cyc", t_done, 29);
        chk("e_end", c_end, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
